// File: rtl/apb3_pkg.sv
// apb3_pkg: shared APB3 state encoding and requester response record
package apb3_pkg;
  localparam int APB_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state;
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } apb3_rsp_t;
endpackage

// File: rtl/apb3_master_if.sv
// apb3_master_if: APB3 bus between one requester and one completer
interface apb3_master_if #(
  parameter int N_BIT_DATA    = 32,
  parameter int N_BIT_ADDRESS = 4
) ();
  logic                     PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [N_BIT_ADDRESS-1:0] PADDR;
  logic [N_BIT_DATA-1:0]    PWDATA, PRDATA;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb3_master_wait_timer.sv
// apb3_wait_timer: saturating ACCESS wait-state counter with expiry flag
module apb3_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  if (TIMEOUT_CYCLES > 0) begin : g_on
    logic [W-1:0] cnt;
    // count stalled ACCESS cycles, holding at the limit so it never wraps
    always_ff @(posedge PCLK or negedge PRESETn)
      if (!PRESETn) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !expired) cnt <= cnt + 1'b1;
    assign expired = cnt == W'(TIMEOUT_CYCLES);
  end else begin : g_off
    assign expired = 1'b0;
  end
endmodule

// File: rtl/apb3_master.sv
// apb3_master: valid/ready command to APB3 SETUP/ACCESS requester with wait-state timeout
module apb3_master import apb3_pkg::*; #(
  parameter int N_BIT_DATA     = 32,
  parameter int N_BIT_ADDRESS  = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [N_BIT_ADDRESS-1:0] cmd_addr,
  input  logic [N_BIT_DATA-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  output logic [N_BIT_DATA-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic                     rsp_timeout,
  apb3_master_if.master            apb
);
  apb_state  state_q, state_d;
  apb3_rsp_t rsp_q, rsp_d;
  logic      cap, done, to, expired;
  apb3_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (state_q == SETUP),
    .en      (state_q == ACCESS && !apb.PREADY),
    .expired (expired)
  );
  // next state, command acceptance and completion/abort decode
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    cap       = 1'b0;
    done      = 1'b0;
    to        = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        cap       = cmd_valid;
        state_d   = cmd_valid ? SETUP : IDLE;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        done      = apb.PREADY;
        to        = !apb.PREADY && expired;
        cmd_ready = apb.PREADY;
        cap       = apb.PREADY && cmd_valid;
        state_d   = apb.PREADY ? (cmd_valid ? SETUP : IDLE) : (expired ? IDLE : ACCESS);
      end
      default: state_d = IDLE;
    endcase
    rsp_d = '{rdata:   (done && !apb.PWRITE) ? APB_DATA_W'(apb.PRDATA) : '0,
              error:   done ? apb.PSLVERR : to,
              timeout: to};
  end
  // state, captured command and one-cycle response registers
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q   <= IDLE;
      apb.PWRITE <= 1'b0;
      apb.PADDR  <= '0;
      apb.PWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= done || to;
      rsp_q     <= rsp_d;
      if (cap) begin
        apb.PWRITE <= cmd_write;
        apb.PADDR  <= cmd_addr;
        apb.PWDATA <= cmd_wdata;
      end
    end
  assign apb.PSEL    = state_q != IDLE;
  assign apb.PENABLE = state_q == ACCESS;
  assign rsp_rdata   = N_BIT_DATA'(rsp_q.rdata);
  assign rsp_error   = rsp_q.error;
  assign rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb3_master.sv
// tb_apb3_master: scoreboard bench for apb3_master against a programmable-wait completer model
module tb_apb3_master;
  typedef struct packed {logic [31:0] rdata; logic err; logic to;} exp_t;
  logic PCLK = 0, PRESETn = 0;
  logic cmd_valid = 0, cmd_write = 0;
  logic [3:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic cmd_ready, rsp_valid, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  int waits = 0, acc = 0, tests = 0, fails = 0;
  logic use_ov = 0, err = 0;
  logic [31:0] ov = 0;
  logic [31:0] mem [16];
  exp_t q[$];
  exp_t e;
  apb3_master_if #(.N_BIT_DATA(32), .N_BIT_ADDRESS(4)) bus ();
  apb3_master #(.N_BIT_DATA(32), .N_BIT_ADDRESS(4), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout), .apb(bus)
  );
  always #5 PCLK = ~PCLK;
  assign bus.PREADY  = acc >= waits;
  assign bus.PRDATA  = use_ov ? ov : mem[bus.PADDR];
  assign bus.PSLVERR = err;
  always @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      acc <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 0;
    end else if (bus.PSEL && bus.PENABLE) begin
      acc <= acc + 1;
      if (bus.PREADY && bus.PWRITE) mem[bus.PADDR] <= bus.PWDATA;
    end else acc <= 0;
  task send(input logic w, input logic [3:0] a, input logic [31:0] d);
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge PCLK);
    @(posedge PCLK);
    #1 cmd_valid = 0;
  endtask
  task wait_rsp(output bit ok, output int cyc, output int en);
    ok = 0; cyc = 0; en = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge PCLK);
      cyc++;
      if (bus.PENABLE) en++;
      ok = rsp_valid;
    end
  endtask
  task test_reset;
    int bad;
    #12;
    tests++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== '0) begin fails++; $display("FAIL reset_apb: got %b/%b/%b/%h/%h want zeros", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA); end
    tests++; if ({rsp_valid, rsp_rdata, rsp_error, rsp_timeout, cmd_ready} !== 35'd1) begin fails++; $display("FAIL reset_rsp: got v=%b d=%h e=%b t=%b rdy=%b want 0/0/0/0/1", rsp_valid, rsp_rdata, rsp_error, rsp_timeout, cmd_ready); end
    @(negedge PCLK) PRESETn = 1;
    waits = 1000;
    send(0, 4'h4, 0);
    repeat (3) @(negedge PCLK);
    tests++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin fails++; $display("FAIL mid_access: got psel/pen=%b%b want 11", bus.PSEL, bus.PENABLE); end
    #2 PRESETn = 0;
    #1;
    tests++; if ({bus.PSEL, bus.PENABLE, rsp_valid, bus.PADDR} !== 7'd0) begin fails++; $display("FAIL async_reset: got psel=%b pen=%b v=%b addr=%h want 0", bus.PSEL, bus.PENABLE, rsp_valid, bus.PADDR); end
    @(negedge PCLK) PRESETn = 1;
    waits = 0;
    bad = 0;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid || bus.PSEL) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL post_reset_idle: got %0d busy cycles want 0", bad); end
  endtask
  task test_write_read;
    bit ok; int cyc, en;
    waits = 0; use_ov = 0; err = 0;
    send(1, 4'h3, 32'hDEADBEEF);
    e = '{32'h0, 1'b0, 1'b0}; q.push_back(e);
    @(negedge PCLK);
    tests++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin fails++; $display("FAIL wr_setup: got %b%b want 10", bus.PSEL, bus.PENABLE); end
    @(negedge PCLK);
    tests++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b111, 4'h3, 32'hDEADBEEF}) begin fails++; $display("FAIL wr_access: got %b%b%b a=%h d=%h want 111 a=3 d=deadbeef", bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA); end
    @(negedge PCLK);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rsp_cycle: got v=%b want 1", rsp_valid); end
    if (rsp_valid) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL wr_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
    send(0, 4'h3, 0);
    e = '{32'hDEADBEEF, 1'b0, 1'b0}; q.push_back(e);
    wait_rsp(ok, cyc, en);
    tests++; if (!ok || cyc !== 3) begin fails++; $display("FAIL rd_latency: got ok=%0d cyc=%0d want 1/3", ok, cyc); end
    if (ok) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL rd_back: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
  endtask
  task test_wait_read;
    bit ok; int cyc, en;
    waits = 3; use_ov = 1; ov = 32'h12345678; err = 1;
    send(0, 4'h5, 0);
    e = '{32'h12345678, 1'b1, 1'b0}; q.push_back(e);
    wait_rsp(ok, cyc, en);
    tests++; if (!ok || en !== 4 || cyc !== 6) begin fails++; $display("FAIL wait_timing: got ok=%0d pen=%0d cyc=%0d want 1/4/6", ok, en, cyc); end
    if (ok) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL wait_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
    waits = 0; use_ov = 0; err = 0;
  endtask
  task test_back_to_back;
    int pulses, bad;
    logic [3:0] a;
    pulses = 0; bad = 0; a = 4'h8;
    @(negedge PCLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_wdata = {8{a}};
    e = '{32'h0, 1'b0, 1'b0}; q.push_back(e);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle_ready: got %b want 1", cmd_ready); end
    @(posedge PCLK);
    for (int k = 1; k <= 9; k++) begin
      @(negedge PCLK);
      if ({bus.PSEL, bus.PENABLE} !== {k <= 8, k <= 8 && k % 2 == 0}) bad++;
      if (rsp_valid !== (k >= 3 && k % 2 == 1)) bad++;
      if (k % 2 == 0 && k <= 8 && (bus.PADDR !== 4'(7 + k / 2) || cmd_ready !== 1'b1)) bad++;
      if (rsp_valid) begin
        pulses++;
        e = q.pop_front();
        if ({rsp_rdata, rsp_error, rsp_timeout} !== e) bad++;
      end
      if (k == 1 || k == 3 || k == 5) begin
        a = a + 1;
        cmd_addr = a; cmd_wdata = {8{a}};
        e = '{32'h0, 1'b0, 1'b0}; q.push_back(e);
      end
      if (k == 7) cmd_valid = 0;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL b2b_sequence: got %0d bad cycles want 0", bad); end
    tests++; if (pulses !== 4) begin fails++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
    tests++; if (mem[11] !== 32'hBBBBBBBB) begin fails++; $display("FAIL b2b_last_write: got %h want bbbbbbbb", mem[11]); end
  endtask
  task test_timeout;
    bit ok; int cyc, en;
    waits = 1000;
    send(0, 4'h2, 0);
    e = '{32'h0, 1'b1, 1'b1}; q.push_back(e);
    wait_rsp(ok, cyc, en);
    tests++; if (!ok || en !== 17 || cyc !== 19 || bus.PSEL !== 1'b0) begin fails++; $display("FAIL to_timing: got ok=%0d pen=%0d cyc=%0d psel=%b want 1/17/19/0", ok, en, cyc, bus.PSEL); end
    if (ok) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL to_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
    waits = 0;
    send(1, 4'h1, 32'hA5A5A5A5);
    e = '{32'h0, 1'b0, 1'b0}; q.push_back(e);
    wait_rsp(ok, cyc, en);
    tests++; if (!ok || cyc !== 3) begin fails++; $display("FAIL to_recover: got ok=%0d cyc=%0d want 1/3", ok, cyc); end
    if (ok) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL to_recover_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
  endtask
  task test_timeout_boundary;
    bit ok; int cyc, en;
    waits = 16;
    send(0, 4'h3, 0);
    e = '{32'hDEADBEEF, 1'b0, 1'b0}; q.push_back(e);
    wait_rsp(ok, cyc, en);
    tests++; if (!ok || en !== 17) begin fails++; $display("FAIL edge_timing: got ok=%0d pen=%0d want 1/17", ok, en); end
    if (ok) begin
      e = q.pop_front();
      tests++; if ({rsp_rdata, rsp_error, rsp_timeout} !== e) begin fails++; $display("FAIL edge_rsp: got %h/%b/%b want %h/%b/%b", rsp_rdata, rsp_error, rsp_timeout, e.rdata, e.err, e.to); end
    end
    waits = 0;
  endtask
  initial begin
    test_reset;
    test_write_read;
    test_wait_read;
    test_back_to_back;
    test_timeout;
    test_timeout_boundary;
    tests++; if (q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d pending want 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
